alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (ADD/SUB/AND/OR/XOR/SLT/SLTU/SLL/SRL/SRA) between NUM_REQ requesters, e.g. the core execute stage and an address-generation/CSR helper.
- Round-robin arbitration picks one valid request per cycle and drives it onto the ALU operand bus.
- The ALU outcome is captured in a one-entry response register and returned tagged with the requester ID over a valid/ready handshake.

---
 rtl/alu_share_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Time-shares one external combinational ALU between NUM_REQ requesters.
//   - A round-robin arbiter picks one valid request per cycle.
//   - The granted request's operands and control code are driven onto the
//     ALU bus.
//   - The ALU outcome is captured in a one-entry response register.
//   - The response is returned with the originating requester ID over a
//     valid/ready handshake.
//   - The register drains and refills on the same edge, so throughput is one
//     operation per cycle while rsp_ready is held high.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req_valid[NUM_REQ]       per-requester request valid
//   req_ready[NUM_REQ]       per-requester accept, one-hot or zero
//   req_srca/req_srcb        flattened operands, requester i at [i*XLEN +: XLEN]
//   req_ctrl                 flattened 4-bit ALU codes, requester i at [i*4 +: 4]
//   alu_srca/srcb/ctrl       operand bus to the shared ALU
//   alu_result, alu_zero     combinational ALU outcome for the current bus
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   index of the requester that produced the response
//   rsp_result, rsp_zero     captured ALU outcome
//   rsp_err                  captured control code was undefined (> 4'b1001)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_srca,
    input  logic [NUM_REQ*XLEN-1:0] req_srcb,
    input  logic [NUM_REQ*4-1:0]    req_ctrl,
    output logic [XLEN-1:0]         alu_srca,
    output logic [XLEN-1:0]         alu_srcb,
    output logic [3:0]              alu_ctrl,
    input  logic [XLEN-1:0]         alu_result,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [XLEN-1:0]         rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Highest defined ALU control code. Codes above it are flagged as errors.
    localparam logic [3:0] CTRL_MAX = 4'b1001;

    // NUM_REQ <= 2**ID_W, so an index plus an offset below NUM_REQ always
    // fits in ID_W+1 bits. One conditional subtract is enough for the modulo.
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_rsp_id;
    logic [XLEN-1:0] r_rsp_result;
    logic            r_rsp_zero;
    logic            r_rsp_err;

    logic [0:0]      w_state_next;
    logic [ID_W-1:0] w_rr_ptr_next;

    // -------------------------------------------------------------------------
    // Unpack the flattened request buses
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] w_srca [NUM_REQ];
    logic [XLEN-1:0] w_srcb [NUM_REQ];
    logic [3:0]      w_ctrl [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_srca[gi] = req_srca[gi*XLEN +: XLEN];
            assign w_srcb[gi] = req_srcb[gi*XLEN +: XLEN];
            assign w_ctrl[gi] = req_ctrl[gi*4 +: 4];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin scan order
    //
    // Scan slot k looks at requester (rr_ptr + k) mod NUM_REQ. Slot 0 is the
    // highest priority, so the requester just after the last winner goes first.
    // -------------------------------------------------------------------------
    logic [ID_W-1:0]    w_scan_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_scan_hit;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [ID_W:0] w_sum;
            assign w_sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(gi);
            assign w_scan_idx[gi] = (w_sum >= NUM_REQ_W) ? ID_W'(w_sum - NUM_REQ_W)
                                                         : w_sum[ID_W-1:0];
            assign w_scan_hit[gi] = req_valid[w_scan_idx[gi]];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Priority pick over the rotated order
    //
    // The loop walks from the lowest-priority slot to the highest, so the last
    // assignment wins. With no valid request, w_gnt stays at rr_ptr. That
    // gives a deterministic ALU operand selection when nothing is granted.
    // -------------------------------------------------------------------------
    logic            w_gnt_valid;
    logic [ID_W-1:0] w_gnt;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt       = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_scan_hit[k]) begin
                w_gnt_valid = 1'b1;
                w_gnt       = w_scan_idx[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accept / capture qualification
    //
    // The register can take a new result when it is empty or being drained this
    // cycle. rst_n gates w_capture so req_ready stays low for the whole
    // reset assertion. The registers alone would not guarantee that, because
    // EMPTY would otherwise advertise acceptance.
    // -------------------------------------------------------------------------
    logic w_can_accept;
    logic w_capture;

    assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
    assign w_capture    = w_gnt_valid & w_can_accept & rst_n;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_capture & (w_gnt == ID_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Shared ALU operand bus
    // -------------------------------------------------------------------------
    assign alu_srca = w_srca[w_gnt];
    assign alu_srcb = w_srcb[w_gnt];
    assign alu_ctrl = w_ctrl[w_gnt];

    // -------------------------------------------------------------------------
    // Pointer advance: the requester after the winner gets first look next time
    // -------------------------------------------------------------------------
    logic [ID_W:0] w_gnt_inc;

    assign w_gnt_inc     = {1'b0, w_gnt} + (ID_W + 1)'(1);
    assign w_rr_ptr_next = (w_gnt_inc == NUM_REQ_W) ? '0 : w_gnt_inc[ID_W-1:0];

    // -------------------------------------------------------------------------
    // Response FSM
    //
    // FULL with rsp_ready high drains the register. A capture on the same edge
    // refills it, so the state stays FULL with no bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_capture) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready) begin
                    w_state_next = w_capture ? ST_FULL : ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_rr_ptr     <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                // Undefined codes still capture the ALU output (expected zero).
                // The error flag lets the requester tell that apart from a real
                // zero result.
                r_rsp_result <= alu_result;
                r_rsp_zero   <= alu_zero;
                r_rsp_id     <= w_gnt;
                r_rsp_err    <= (alu_ctrl > CTRL_MAX);
                r_rr_ptr     <= w_rr_ptr_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response outputs come straight from registers, so there is no
    // combinational path from rsp_ready to rsp_*.
    // -------------------------------------------------------------------------
    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter with NUM_REQ=2, XLEN=32. A small
// behavioural ALU is attached to the operand bus. All expected values below are
// worked out by hand from the operands driven in each step.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int XLEN    = 32;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*XLEN-1:0] req_srca;
    logic [NUM_REQ*XLEN-1:0] req_srcb;
    logic [NUM_REQ*4-1:0]    req_ctrl;
    logic [XLEN-1:0]         alu_srca;
    logic [XLEN-1:0]         alu_srcb;
    logic [3:0]              alu_ctrl;
    logic [XLEN-1:0]         alu_result;
    logic                    alu_zero;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [XLEN-1:0]         rsp_result;
    logic                    rsp_zero;
    logic                    rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .XLEN    (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_ctrl   (req_ctrl),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU attached to the DUT's operand bus.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'd0: alu_result = alu_srca + alu_srcb;
            4'd1: alu_result = alu_srca - alu_srcb;
            4'd2: alu_result = alu_srca & alu_srcb;
            4'd3: alu_result = alu_srca | alu_srcb;
            4'd4: alu_result = alu_srca ^ alu_srcb;
            4'd5: alu_result = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
            4'd6: alu_result = (alu_srca < alu_srcb) ? 32'd1 : 32'd0;
            4'd7: alu_result = alu_srca << alu_srcb[4:0];
            4'd8: alu_result = alu_srca >> alu_srcb[4:0];
            4'd9: alu_result = 32'($signed(alu_srca) >>> alu_srcb[4:0]);
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        if (obs === exp) $display("ok   %s: %h", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        req_srca[i*XLEN +: XLEN] = a;
        req_srcb[i*XLEN +: XLEN] = b;
        req_ctrl[i*4 +: 4]       = c;
    endtask

    initial begin
        // ---------------- Reset with both requesters valid ----------------
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_srca  = '0;
        req_srcb  = '0;
        req_ctrl  = '0;
        set_req(0, 32'd5, 32'd7, 4'b0000);   // 5+7 = 12
        set_req(1, 32'd9, 32'd9, 4'b0001);   // 9-9 = 0
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_rsp_result", rsp_result,    32'd0);
        chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);

        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b01);
        tick();
        chk("first_valid",  32'(rsp_valid), 32'd1);
        chk("first_id",     32'(rsp_id),    32'd0);
        chk("first_result", rsp_result,     32'd12);
        chk("first_zero",   32'(rsp_zero),  32'd0);
        chk("first_err",    32'(rsp_err),   32'd0);
        // Pointer has moved to 1, and draining allows an immediate re-accept.
        chk("b2b_ready", 32'(req_ready), 32'b10);
        req_valid = 2'b00;
        tick();
        chk("drain_empty", 32'(rsp_valid), 32'd0);

        // ---------------- Single requesters ----------------
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("r0_valid",  32'(rsp_valid), 32'd1);
        chk("r0_id",     32'(rsp_id),    32'd0);
        chk("r0_result", rsp_result,     32'd12);
        chk("r0_zero",   32'(rsp_zero),  32'd0);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        chk("r1_id",     32'(rsp_id),   32'd1);
        chk("r1_result", rsp_result,    32'd0);
        chk("r1_zero",   32'(rsp_zero), 32'd1);
        chk("r1_err",    32'(rsp_err),  32'd0);
        tick();
        chk("r1_drain", 32'(rsp_valid), 32'd0);

        // ---------------- Round-robin, both valid, 6 cycles ----------------
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_valid",  32'(rsp_valid), 32'd1);
            chk("rr_id",     32'(rsp_id),    32'(i % 2));
            chk("rr_result", rsp_result,     (i % 2 == 0) ? 32'd12 : 32'd0);
        end

        // ---------------- Backpressure for 3 cycles ----------------
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready_now", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready",  32'(req_ready), 32'd0);
            chk("bp_valid",  32'(rsp_valid), 32'd1);
            chk("bp_id",     32'(rsp_id),    32'd1);
            chk("bp_result", rsp_result,     32'd0);
            chk("bp_zero",   32'(rsp_zero),  32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b01);
        tick();
        chk("bp_next_valid",  32'(rsp_valid), 32'd1);
        chk("bp_next_id",     32'(rsp_id),    32'd0);
        chk("bp_next_result", rsp_result,     32'd12);
        req_valid = 2'b00;
        tick();
        chk("bp_drain", 32'(rsp_valid), 32'd0);

        // ---------------- SRA and undefined op ----------------
        // The pointer is now 1. With no request, the bus shows requester 1.
        set_req(1, 32'h8000_0000, 32'd4, 4'b1001);
        #1;
        chk("idle_bus_srca", alu_srca, 32'h8000_0000);
        req_valid = 2'b10;
        #1;
        chk("sra_bus_ctrl", 32'(alu_ctrl), 32'd9);
        tick();
        chk("sra_id",     32'(rsp_id),   32'd1);
        chk("sra_result", rsp_result,    32'hF800_0000);
        chk("sra_zero",   32'(rsp_zero), 32'd0);
        chk("sra_err",    32'(rsp_err),  32'd0);
        set_req(1, 32'h8000_0000, 32'd4, 4'b1100);
        tick();
        chk("undef_result", rsp_result,    32'd0);
        chk("undef_zero",   32'(rsp_zero), 32'd1);
        chk("undef_err",    32'(rsp_err),  32'd1);
        chk("undef_id",     32'(rsp_id),   32'd1);
        req_valid = 2'b00;
        tick();
        chk("undef_drain", 32'(rsp_valid), 32'd0);

        // ---------------- Asynchronous reset mid-operation ----------------
        // The pointer is 0. Granting requester 0 moves it to 1 before the reset.
        set_req(0, 32'd1, 32'd2, 4'b0000);   // 1+2 = 3
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        chk("pre_rst_valid",  32'(rsp_valid), 32'd1);
        chk("pre_rst_result", rsp_result,     32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  32'(rsp_valid), 32'd0);
        chk("async_rst_result", rsp_result,     32'd0);
        chk("async_rst_ready",  32'(req_ready), 32'd0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_async_valid", 32'(rsp_valid), 32'd0);
        // A pointer that restarted at 0 favours requester 0.
        chk("post_async_ready", 32'(req_ready), 32'b01);
        tick();
        chk("post_async_id",     32'(rsp_id),    32'd0);
        chk("post_async_rvalid", 32'(rsp_valid), 32'd1);
        chk("post_async_result", rsp_result,     32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
